// File: rtl/duck_round_controller.sv
// duck_round_controller
// Runs one round of the duck game around the gun-firing path. It spawns
// ducks, gives each duck a fixed amount of ammo, turns trigger presses into
// single shot pulses, and opens a fixed-length light-flash hit window after
// each shot. Each shot is resolved as a hit or a miss, and the number of
// ducks hit is counted over the round.
//
// Handshakes: there is no valid/ready flow here. Every output is a registered
// level or a one-cycle pulse, and every input is sampled on the rising clk
// edge (trigger goes through its own synchronizer first).
//
// Ports:
//   clk, reset_n  - clock; asynchronous active-low reset
//   start         - begins a round from IDLE or ROUND_END
//   trigger       - raw gun trigger (asynchronous, active-high)
//   hit           - light-sensor hit; only used while flash=1
//   duck_escaped  - one-cycle pulse: the current duck left the screen
//   duck_spawn    - one-cycle pulse: launch the next duck
//   shot_fire     - one-cycle pulse for each accepted shot
//   flash         - high during the hit window
//   duck_shot     - one-cycle pulse: the current duck was hit
//   ammo          - shots left for the current duck
//   duck_idx      - index of the current duck, counting from 0
//   ducks_hit     - ducks hit this round
//   round_over    - high while the round has ended
module duck_round_controller #(
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int FLASH_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       trigger,
  input  logic       hit,
  input  logic       duck_escaped,
  output logic       duck_spawn,
  output logic       shot_fire,
  output logic       flash,
  output logic       duck_shot,
  output logic [1:0] ammo,
  output logic [3:0] duck_idx,
  output logic [3:0] ducks_hit,
  output logic       round_over
);

  localparam logic [1:0] AMMO_LOAD  = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0] LAST_DUCK  = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0] HIT_MAX    = 4'(DUCKS_PER_ROUND);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SPAWN     = 3'd1,
    S_ARMED     = 3'd2,
    S_FLASH     = 3'd3,
    S_RESOLVE   = 3'd4,
    S_DUCK_DONE = 3'd5,
    S_ROUND_END = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic       hit_latch_q, hit_latch_d;
  logic [1:0] ammo_d;
  logic [3:0] duck_idx_d, ducks_hit_d;
  logic       shot_fire_d, duck_shot_d;

  // Trigger path. The synchronizer and the edge-detect history reset to 1.
  // Because of this, a trigger held through reset looks like "already
  // pressed" and has to be released before it can fire.
  logic trig_sync1, trig_sync2, trig_prev, trig_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_sync1 <= 1'b1;
      trig_sync2 <= 1'b1;
      trig_prev  <= 1'b1;
    end else begin
      trig_sync1 <= trigger;
      trig_sync2 <= trig_sync1;
      trig_prev  <= trig_sync2;
    end
  end

  assign trig_edge = trig_sync2 & ~trig_prev;

  // Next-state logic. Pulse outputs are computed from the transition, so
  // they are registered together with the state.
  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    hit_latch_d = hit_latch_q;
    ammo_d      = ammo;
    duck_idx_d  = duck_idx;
    ducks_hit_d = ducks_hit;
    shot_fire_d = 1'b0;
    duck_shot_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          duck_idx_d  = 4'd0;
          ducks_hit_d = 4'd0;
          state_d     = S_SPAWN;
        end
      end
      S_SPAWN: begin
        ammo_d      = AMMO_LOAD;
        hit_latch_d = 1'b0;
        state_d     = S_ARMED;
      end
      S_ARMED: begin
        // If the duck escapes in the same cycle as a trigger edge, the
        // escape wins and the press is dropped.
        if (duck_escaped) begin
          state_d = S_DUCK_DONE;
        end else if (trig_edge && ammo != 2'd0) begin
          shot_fire_d = 1'b1;
          ammo_d      = ammo - 2'd1;
          flash_cnt_d = FLASH_LOAD;
          state_d     = S_FLASH;
        end
      end
      S_FLASH: begin
        // duck_escaped is ignored on purpose: the shot that is in flight
        // must be resolved first.
        if (hit) hit_latch_d = 1'b1;
        if (flash_cnt_q <= 8'd1) state_d = S_RESOLVE;
        else flash_cnt_d = flash_cnt_q - 8'd1;
      end
      S_RESOLVE: begin
        if (hit_latch_q) begin
          duck_shot_d = 1'b1;
          if (ducks_hit < HIT_MAX) ducks_hit_d = ducks_hit + 4'd1;
          state_d = S_DUCK_DONE;
        end else if (ammo == 2'd0) begin
          state_d = S_DUCK_DONE;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_DUCK_DONE: begin
        if (duck_idx >= LAST_DUCK) begin
          state_d = S_ROUND_END;
        end else begin
          duck_idx_d = duck_idx + 4'd1;
          state_d    = S_SPAWN;
        end
      end
      S_ROUND_END: begin
        if (start) begin
          duck_idx_d  = 4'd0;
          ducks_hit_d = 4'd0;
          state_d     = S_SPAWN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      flash_cnt_q <= 8'd0;
      hit_latch_q <= 1'b0;
      ammo        <= 2'd0;
      duck_idx    <= 4'd0;
      ducks_hit   <= 4'd0;
      duck_spawn  <= 1'b0;
      shot_fire   <= 1'b0;
      flash       <= 1'b0;
      duck_shot   <= 1'b0;
      round_over  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flash_cnt_q <= flash_cnt_d;
      hit_latch_q <= hit_latch_d;
      ammo        <= ammo_d;
      duck_idx    <= duck_idx_d;
      ducks_hit   <= ducks_hit_d;
      duck_spawn  <= (state_d == S_SPAWN);
      shot_fire   <= shot_fire_d;
      flash       <= (state_d == S_FLASH);
      duck_shot   <= duck_shot_d;
      round_over  <= (state_d == S_ROUND_END);
    end
  end

endmodule

// File: tb/tb_duck_round_controller.sv
// Testbench for duck_round_controller.
// The driver tasks apply game actions (start, trigger press, escape) and
// update a behavioural game model. The model pushes the DUT output events it
// expects into exp_q. A separate monitor process turns the DUT output pulses
// into event records, pops the queue and compares each record.
module tb_duck_round_controller;

  localparam int SHOTS = 3;
  localparam int DUCKS = 10;
  localparam int FLASH = 4;
  localparam int W     = 29;

  localparam logic [2:0] EV_SPAWN = 3'd1;
  localparam logic [2:0] EV_SHOT  = 3'd2;
  localparam logic [2:0] EV_FLASH = 3'd3;
  localparam logic [2:0] EV_DSHOT = 3'd4;
  localparam logic [2:0] EV_OVER  = 3'd5;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       trigger;
  logic       hit;
  logic       duck_escaped;
  logic       duck_spawn;
  logic       shot_fire;
  logic       flash;
  logic       duck_shot;
  logic [1:0] ammo;
  logic [3:0] duck_idx;
  logic [3:0] ducks_hit;
  logic       round_over;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Game model: current duck, hits, ammo left, and whether a round is live.
  int m_idx, m_hits, m_ammo;
  bit m_active;

  duck_round_controller #(
    .SHOTS_PER_DUCK (SHOTS),
    .DUCKS_PER_ROUND(DUCKS),
    .FLASH_CYCLES   (FLASH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .trigger     (trigger),
    .hit         (hit),
    .duck_escaped(duck_escaped),
    .duck_spawn  (duck_spawn),
    .shot_fire   (shot_fire),
    .flash       (flash),
    .duck_shot   (duck_shot),
    .ammo        (ammo),
    .duck_idx    (duck_idx),
    .ducks_hit   (ducks_hit),
    .round_over  (round_over)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event record: kind, duck index, hits, ammo, aux
  // (aux = cycle for a shot, width for a flash, 0 otherwise)
  function automatic logic [W-1:0] mk(input logic [2:0] k, input logic [3:0] i,
                                      input logic [3:0] h, input logic [1:0] a,
                                      input logic [15:0] x);
    return {k, i, h, a, x};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string name);
    logic [14:0] got;
    got = {duck_spawn, shot_fire, flash, duck_shot, ammo, duck_idx, ducks_hit, round_over};
    n_cmp++;
    if (got !== 15'd0) begin
      n_bad++;
      $display("FAIL %s: outputs=%h, required 0", name, got);
    end
  endtask

  task automatic check_display(input string name, input logic [3:0] idx,
                               input logic [3:0] hits, input logic over);
    n_cmp++;
    if ({duck_idx, ducks_hit, round_over} !== {idx, hits, over}) begin
      n_bad++;
      $display("FAIL %s: idx=%0d hits=%0d over=%0d, required idx=%0d hits=%0d over=%0d",
               name, duck_idx, ducks_hit, round_over, idx, hits, over);
    end
  endtask

  // Model: the current duck is finished (hit, out of ammo, or escaped).
  task automatic model_duck_done();
    if (m_idx == DUCKS - 1) begin
      exp_q.push_back(mk(EV_OVER, 4'(m_idx), 4'(m_hits), 2'd0, 16'd0));
      m_active = 1'b0;
    end else begin
      m_idx++;
      m_ammo = SHOTS;
      exp_q.push_back(mk(EV_SPAWN, 4'(m_idx), 4'(m_hits), 2'(m_ammo), 16'd0));
    end
  endtask

  // Driver: pulse start. It only has an effect when no round is live.
  task automatic do_start();
    if (!m_active) begin
      m_idx    = 0;
      m_hits   = 0;
      m_ammo   = SHOTS;
      m_active = 1'b1;
      exp_q.push_back(mk(EV_SPAWN, 4'd0, 4'd0, 2'(SHOTS), 16'd0));
    end
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(4);
  endtask

  // Driver: the duck escapes while the controller is armed.
  task automatic do_escape();
    if (m_active) model_duck_done();
    duck_escaped = 1'b1;
    wait_cycles(1);
    duck_escaped = 1'b0;
    wait_cycles(6);
  endtask

  // Driver: one trigger press. The trigger is first sampled at cycle n+1.
  //   do_hit: pulse hit during flash cycle k+1 (k = 0..3)
  //   esc:    1 = escape in the same cycle as the trigger edge
  //           2 = escape during the flash window
  //   dbl:    release and press again while the flash is on
  //   hold:   cycles the trigger stays held
  //   rst_at: if nonzero, pulse reset_n low partway through the press
  task automatic do_press(input bit do_hit, input int k, input int esc,
                          input bit dbl, input int hold, input int rst_at);
    int n;
    n = cyc;
    if (m_active) begin
      if (esc == 1) begin
        model_duck_done();
      end else begin
        m_ammo--;
        exp_q.push_back(mk(EV_SHOT, 4'(m_idx), 4'(m_hits), 2'(m_ammo), 16'(n + 3)));
        exp_q.push_back(mk(EV_FLASH, 4'd0, 4'd0, 2'd0, 16'(FLASH)));
        if (do_hit) begin
          if (m_hits < DUCKS) m_hits++;
          exp_q.push_back(mk(EV_DSHOT, 4'(m_idx), 4'(m_hits), 2'd0, 16'd0));
          model_duck_done();
        end else if (m_ammo == 0) begin
          model_duck_done();
        end
      end
    end
    trigger = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (dbl) trigger = (i >= 3 && i <= 4);
      else trigger = (i < hold);
      // On a miss, hit is pulsed outside the flash window; it must be ignored.
      hit = (do_hit && i == 3 + k) || (!do_hit && i == 12);
      duck_escaped = (esc == 1 && i == 2) || (esc == 2 && i == 4);
      if (i == rst_at) begin
        #1;
        reset_n = 1'b0;
        #1;
        check_reset("mid_flash_reset");
        exp_q.delete();
        m_active = 1'b0;
      end
      if (rst_at != 0 && i == rst_at + 2) reset_n = 1'b1;
    end
    trigger      = 1'b0;
    hit          = 1'b0;
    duck_escaped = 1'b0;
    wait_cycles(1);
  endtask

  // Monitor: turns the DUT outputs into event records and checks them
  // against the scoreboard.
  task automatic check_event(input logic [W-1:0] got);
    logic [W-1:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got kind=%0d idx=%0d hits=%0d ammo=%0d aux=%0d, required no event",
               got[28:26], got[25:22], got[21:18], got[17:16], got[15:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_bad++;
        $display("FAIL event: got kind=%0d idx=%0d hits=%0d ammo=%0d aux=%0d, required kind=%0d idx=%0d hits=%0d ammo=%0d aux=%0d",
                 got[28:26], got[25:22], got[21:18], got[17:16], got[15:0],
                 exp[28:26], exp[25:22], exp[21:18], exp[17:16], exp[15:0]);
      end
    end
  endtask

  initial begin
    bit spawn_pend;
    bit prev_over;
    int flash_run;
    spawn_pend = 1'b0;
    prev_over  = 1'b0;
    flash_run  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        spawn_pend = 1'b0;
        prev_over  = 1'b0;
        flash_run  = 0;
      end else begin
        // A spawn is reported one cycle later, once the new ammo is loaded.
        if (spawn_pend) begin
          check_event(mk(EV_SPAWN, duck_idx, ducks_hit, ammo, 16'd0));
          spawn_pend = 1'b0;
        end
        if (duck_spawn) spawn_pend = 1'b1;
        if (shot_fire) check_event(mk(EV_SHOT, duck_idx, ducks_hit, ammo, 16'(cyc)));
        if (flash) begin
          flash_run++;
        end else if (flash_run != 0) begin
          check_event(mk(EV_FLASH, 4'd0, 4'd0, 2'd0, 16'(flash_run)));
          flash_run = 0;
        end
        if (duck_shot) check_event(mk(EV_DSHOT, duck_idx, ducks_hit, 2'd0, 16'd0));
        if (round_over && !prev_over) check_event(mk(EV_OVER, duck_idx, ducks_hit, 2'd0, 16'd0));
        prev_over = round_over;
      end
    end
  end

  // Main stimulus
  initial begin
    int r;
    reset_n      = 1'b0;
    start        = 1'b0;
    trigger      = 1'b1;
    hit          = 1'b0;
    duck_escaped = 1'b0;
    m_active     = 1'b0;
    m_idx        = 0;
    m_hits       = 0;
    m_ammo       = 0;

    // Reset with the trigger held high, then start: no shot may fire.
    wait_cycles(3);
    check_reset("reset_state");
    reset_n = 1'b1;
    wait_cycles(4);
    do_start();
    wait_cycles(4);
    trigger = 1'b0;
    wait_cycles(3);

    // Single hit during the 2nd flash cycle
    do_press(1'b1, 1, 0, 1'b0, 2, 0);
    // Three misses use up the ammo, and the duck is lost
    for (int i = 0; i < 3; i++) do_press(1'b0, 0, 0, 1'b0, $urandom_range(1, 5), 0);
    // Escape in the same cycle as the trigger edge
    do_press(1'b0, 0, 1, 1'b0, 2, 0);
    // Escape during the flash is ignored, and the hit still counts
    do_press(1'b1, $urandom_range(0, 3), 2, 1'b0, 3, 0);
    // A second press during the flash is dropped
    do_press(1'b0, 0, 0, 1'b1, 1, 0);

    // Random play until the round ends
    for (int a = 0; a < 300 && m_active; a++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: do_escape();
        1: do_press(1'b0, 0, 1, 1'b0, $urandom_range(1, 5), 0);
        2: do_start();
        default: do_press(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0) ? 2 : 0,
                          ($urandom_range(0, 4) == 0), $urandom_range(1, 5), 0);
      endcase
    end
    // A press in ROUND_END is dropped
    do_press(1'b1, 0, 0, 1'b0, 2, 0);

    // Full round alternating hit and miss: 5 hits, last index 9
    do_start();
    for (int d = 0; d < DUCKS; d++) begin
      if (d % 2 == 0) do_press(1'b1, $urandom_range(0, 3), 0, 1'b0, $urandom_range(1, 5), 0);
      else do_escape();
    end
    check_display("round_end_display", 4'd9, 4'd5, 1'b1);
    do_start();
    check_display("restart_cleared", 4'd0, 4'd0, 1'b0);

    // Reset in the middle of the flash window
    do_press(1'b0, 0, 0, 1'b0, 2, 0);
    do_press(1'b0, 0, 0, 1'b0, 2, 0);
    do_escape();
    do_press(1'b1, 0, 0, 1'b0, 2, 5);
    wait_cycles(5);
    check_reset("idle_after_reset");
    // IDLE after reset: a press is dropped, and start begins a new round
    do_press(1'b1, 1, 0, 1'b0, 2, 0);
    do_start();
    do_press(1'b1, 2, 0, 1'b0, 2, 0);
    wait_cycles(10);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d events still expected, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
